// File: rtl/mem_controller.sv
// mem_controller: round-robin arbiter relaying consumer memory requests to a single memory port
// Ports: clk/reset (async, active-low); consumer_read_* and consumer_write_* are flattened
// per-consumer valid/address/data request buses with registered ready/data responses;
// mem_read_* and mem_write_* form the single upstream memory port.
// Define MEM_CONTROLLER_WRITE_EN to build the write path; otherwise the block is read-only.
module mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);
  localparam int CW = $clog2(NUM_CONSUMERS);
  localparam logic [2:0] IDLE          = 3'd0;
  localparam logic [2:0] READ_WAITING  = 3'd1;
  localparam logic [2:0] READ_RELAYING = 3'd2;
`ifdef MEM_CONTROLLER_WRITE_EN
  localparam logic [2:0] WRITE_WAITING  = 3'd3;
  localparam logic [2:0] WRITE_RELAYING = 3'd4;
`endif
  logic [2:0]                     state_q, state_d;
  logic [CW-1:0]                  rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick, idx;
  logic                           found;
  logic [NUM_CONSUMERS-1:0]       req;
  logic                           mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]           mem_read_address_q, mem_read_address_d;
  logic [NUM_CONSUMERS-1:0]       read_ready_q, read_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q, read_data_d;
`ifdef MEM_CONTROLLER_WRITE_EN
  logic                           mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]           mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]           mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]       write_ready_q, write_ready_d;
  assign req = consumer_read_valid | consumer_write_valid;
`else
  logic unused_write;
  assign req = consumer_read_valid;
  assign unused_write = ^{consumer_write_valid, consumer_write_address, consumer_write_data, mem_write_ready};
`endif
  always_comb begin
    state_d            = state_q;
    rr_ptr_d           = rr_ptr_q;
    grant_d            = grant_q;
    mem_read_valid_d   = mem_read_valid_q;
    mem_read_address_d = mem_read_address_q;
    read_ready_d       = read_ready_q;
    read_data_d        = read_data_q;
`ifdef MEM_CONTROLLER_WRITE_EN
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    write_ready_d       = write_ready_q;
`endif
    // Scan from the farthest offset down so the requester closest to rr_ptr wins.
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
      idx = CW'((int'(rr_ptr_q) + i) % NUM_CONSUMERS);
      if (req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        if (consumer_read_valid[pick]) begin
          mem_read_valid_d   = 1'b1;
          mem_read_address_d = consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
          state_d            = READ_WAITING;
        end
`ifdef MEM_CONTROLLER_WRITE_EN
        else begin
          mem_write_valid_d   = 1'b1;
          mem_write_address_d = consumer_write_address[pick*ADDR_BITS +: ADDR_BITS];
          mem_write_data_d    = consumer_write_data[pick*DATA_BITS +: DATA_BITS];
          state_d             = WRITE_WAITING;
        end
`endif
      end
      READ_WAITING: if (mem_read_ready) begin
        read_data_d[grant_q*DATA_BITS +: DATA_BITS] = mem_read_data;
        mem_read_valid_d      = 1'b0;
        read_ready_d[grant_q] = 1'b1;
        state_d               = READ_RELAYING;
      end
      READ_RELAYING: if (!consumer_read_valid[grant_q]) begin
        read_ready_d = '0;
        rr_ptr_d     = CW'((int'(grant_q) + 1) % NUM_CONSUMERS);
        state_d      = IDLE;
      end
`ifdef MEM_CONTROLLER_WRITE_EN
      WRITE_WAITING: if (mem_write_ready) begin
        mem_write_valid_d      = 1'b0;
        write_ready_d[grant_q] = 1'b1;
        state_d                = WRITE_RELAYING;
      end
      WRITE_RELAYING: if (!consumer_write_valid[grant_q]) begin
        write_ready_d = '0;
        rr_ptr_d      = CW'((int'(grant_q) + 1) % NUM_CONSUMERS);
        state_d       = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      rr_ptr_q           <= '0;
      grant_q            <= '0;
      mem_read_valid_q   <= 1'b0;
      mem_read_address_q <= '0;
      read_ready_q       <= '0;
      read_data_q        <= '0;
`ifdef MEM_CONTROLLER_WRITE_EN
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      write_ready_q       <= '0;
`endif
    end else begin
      state_q            <= state_d;
      rr_ptr_q           <= rr_ptr_d;
      grant_q            <= grant_d;
      mem_read_valid_q   <= mem_read_valid_d;
      mem_read_address_q <= mem_read_address_d;
      read_ready_q       <= read_ready_d;
      read_data_q        <= read_data_d;
`ifdef MEM_CONTROLLER_WRITE_EN
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      write_ready_q       <= write_ready_d;
`endif
    end
  end
  assign consumer_read_ready = read_ready_q;
  assign consumer_read_data  = read_data_q;
  assign mem_read_valid      = mem_read_valid_q;
  assign mem_read_address    = mem_read_address_q;
`ifdef MEM_CONTROLLER_WRITE_EN
  assign consumer_write_ready = write_ready_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;
`else
  assign consumer_write_ready = '0;
  assign mem_write_valid      = 1'b0;
  assign mem_write_address    = '0;
  assign mem_write_data       = '0;
`endif
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed self-checking bench for mem_controller
module tb_mem_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  crv = '0, cwv = '0;
  logic [31:0] cra = '0, cwa = '0;
  logic [63:0] cwd = '0;
  logic [3:0]  crr, cwr;
  logic [63:0] crd;
  logic        mrv, mwv;
  logic [7:0]  mra, mwa;
  logic [15:0] mwd;
  logic        mrr = 1'b0, mwr = 1'b0;
  logic [15:0] mrd = '0;
  int checks = 0, failures = 0;

  mem_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic wait_valid(input bit wr, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick;
      ok = wr ? mwv : mrv;
    end
  endtask

  task automatic test_reset;
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({crr, cwr, crd, mrv, mra, mwv, mwa, mwd} !== '0) begin
      failures++;
      $display("FAIL reset_async outputs=%h required 0", {crr, cwr, crd, mrv, mra, mwv, mwa, mwd});
    end
    tick;
    tick;
    reset = 1'b1;
    tick;
    checks++;
    if ({crr, cwr, crd, mrv, mra, mwv, mwa, mwd} !== '0) begin
      failures++;
      $display("FAIL reset_release outputs=%h required 0", {crr, cwr, crd, mrv, mra, mwv, mwa, mwd});
    end
  endtask

  task automatic test_single_read;
    bit ok;
    crv[2] = 1'b1;
    cra[23:16] = 8'h15;
    wait_valid(1'b0, ok);
    checks++;
    if (!ok || mra !== 8'h15) begin
      failures++;
      $display("FAIL single_read_issue valid=%b addr=%h required 1/15", ok, mra);
    end
    mrr = 1'b1;
    mrd = 16'h00A5;
    tick;
    mrr = 1'b0;
    mrd = '0;
    checks++;
    if (crr !== 4'b0100 || crd[47:32] !== 16'h00A5 || mrv !== 1'b0) begin
      failures++;
      $display("FAIL single_read_ack ready=%b data=%h mrv=%b required 0100/00a5/0", crr, crd[47:32], mrv);
    end
    tick;
    tick;
    checks++;
    if (crr !== 4'b0100 || crd[47:32] !== 16'h00A5) begin
      failures++;
      $display("FAIL single_read_hold ready=%b data=%h required 0100/00a5", crr, crd[47:32]);
    end
    crv[2] = 1'b0;
    tick;
    checks++;
    if (crr !== 4'b0000 || crd[47:32] !== 16'h00A5) begin
      failures++;
      $display("FAIL single_read_release ready=%b data=%h required 0000/00a5", crr, crd[47:32]);
    end
  endtask

  task automatic test_round_robin;
    bit ok;
    int e;
    pulse_reset;
    cra = {8'h13, 8'h12, 8'h11, 8'h10};
    crv = 4'hF;
    for (int t = 0; t < 5; t++) begin
      e = t % 4;
      wait_valid(1'b0, ok);
      checks++;
      if (!ok || mra !== 8'(16 + e)) begin
        failures++;
        $display("FAIL rr_grant t=%0d valid=%b addr=%h required %h", t, ok, mra, 8'(16 + e));
      end
      mrr = 1'b1;
      mrd = 16'(16'h1000 + e);
      tick;
      mrr = 1'b0;
      checks++;
      if (crr !== 4'(1 << e) || mrv !== 1'b0) begin
        failures++;
        $display("FAIL rr_ack t=%0d ready=%b mrv=%b required %b/0", t, crr, mrv, 4'(1 << e));
      end
      crv[e] = 1'b0;
      if (t == 4) crv = '0;
      tick;
      checks++;
      if (crr !== 4'b0000 || mrv !== 1'b0) begin
        failures++;
        $display("FAIL rr_release t=%0d ready=%b mrv=%b required 0000/0", t, crr, mrv);
      end
      if (t < 4) crv[e] = 1'b1;
    end
    checks++;
    if (crd !== 64'h1003_1002_1001_1000) begin
      failures++;
      $display("FAIL rr_data data=%h required 1003100210011000", crd);
    end
  endtask

  task automatic test_write;
`ifdef MEM_CONTROLLER_WRITE_EN
    bit ok;
    cwv[1] = 1'b1;
    cwa[15:8] = 8'h40;
    cwd[31:16] = 16'h0F00;
    wait_valid(1'b1, ok);
    checks++;
    if (!ok || mwa !== 8'h40 || mwd !== 16'h0F00 || mrv !== 1'b0) begin
      failures++;
      $display("FAIL write_issue valid=%b addr=%h data=%h mrv=%b required 1/40/0f00/0", ok, mwa, mwd, mrv);
    end
    mwr = 1'b1;
    tick;
    mwr = 1'b0;
    checks++;
    if (cwr !== 4'b0010 || mwv !== 1'b0 || crr !== 4'b0000) begin
      failures++;
      $display("FAIL write_ack wready=%b mwv=%b rready=%b required 0010/0/0000", cwr, mwv, crr);
    end
    cwv[1] = 1'b0;
    tick;
    checks++;
    if (cwr !== 4'b0000) begin
      failures++;
      $display("FAIL write_release wready=%b required 0000", cwr);
    end
`else
    cwv[1] = 1'b1;
    cwa[15:8] = 8'h40;
    cwd[31:16] = 16'h0F00;
    mwr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (mwv !== 1'b0 || mrv !== 1'b0 || cwr !== 4'b0000 || mwa !== 8'h00 || mwd !== 16'h0000) begin
        failures++;
        $display("FAIL write_disabled cyc=%0d mwv=%b mrv=%b wready=%b addr=%h data=%h required all 0", i, mwv, mrv, cwr, mwa, mwd);
      end
    end
    cwv[1] = 1'b0;
    mwr = 1'b0;
`endif
  endtask

  task automatic test_collision;
    bit ok;
    pulse_reset;
    crv[0] = 1'b1;
    cwv[0] = 1'b1;
    cra[7:0] = 8'h01;
    cwa[7:0] = 8'h02;
    cwd[15:0] = 16'hBEEF;
    wait_valid(1'b0, ok);
    checks++;
    if (!ok || mra !== 8'h01 || mwv !== 1'b0) begin
      failures++;
      $display("FAIL collision_read_first valid=%b addr=%h mwv=%b required 1/01/0", ok, mra, mwv);
    end
    mrr = 1'b1;
    mrd = 16'h0101;
    tick;
    mrr = 1'b0;
    checks++;
    if (crr !== 4'b0001 || crd[15:0] !== 16'h0101 || cwr !== 4'b0000) begin
      failures++;
      $display("FAIL collision_read_ack ready=%b data=%h wready=%b required 0001/0101/0000", crr, crd[15:0], cwr);
    end
    crv[0] = 1'b0;
`ifdef MEM_CONTROLLER_WRITE_EN
    wait_valid(1'b1, ok);
    checks++;
    if (!ok || mwa !== 8'h02 || mwd !== 16'hBEEF || mrv !== 1'b0) begin
      failures++;
      $display("FAIL collision_write_second valid=%b addr=%h data=%h mrv=%b required 1/02/beef/0", ok, mwa, mwd, mrv);
    end
    mwr = 1'b1;
    tick;
    mwr = 1'b0;
    checks++;
    if (cwr !== 4'b0001) begin
      failures++;
      $display("FAIL collision_write_ack wready=%b required 0001", cwr);
    end
    cwv[0] = 1'b0;
    tick;
`else
    tick;
    tick;
    tick;
    checks++;
    if (mrv !== 1'b0 || mwv !== 1'b0 || cwr !== 4'b0000 || crr !== 4'b0000) begin
      failures++;
      $display("FAIL collision_write_ignored mrv=%b mwv=%b wready=%b rready=%b required 0/0/0000/0000", mrv, mwv, cwr, crr);
    end
    cwv[0] = 1'b0;
`endif
  endtask

  task automatic test_stall_reset;
    bit ok;
    crv[3] = 1'b1;
    cra[31:24] = 8'h77;
    wait_valid(1'b0, ok);
    checks++;
    if (!ok || mra !== 8'h77) begin
      failures++;
      $display("FAIL stall_issue valid=%b addr=%h required 1/77", ok, mra);
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (mrv !== 1'b1 || mra !== 8'h77 || crr !== 4'b0000) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d mrv=%b addr=%h ready=%b required 1/77/0000", i, mrv, mra, crr);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({crr, cwr, crd, mrv, mra, mwv, mwa, mwd} !== '0) begin
      failures++;
      $display("FAIL stall_reset_async outputs=%h required 0", {crr, cwr, crd, mrv, mra, mwv, mwa, mwd});
    end
    crv[3] = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    checks++;
    if ({crr, cwr, crd, mrv, mra, mwv, mwa, mwd} !== '0) begin
      failures++;
      $display("FAIL stall_reset_idle outputs=%h required 0", {crr, cwr, crd, mrv, mra, mwv, mwa, mwd});
    end
  endtask

  task automatic test_spurious_ready;
    mrr = 1'b1;
    mwr = 1'b1;
    mrd = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (crr !== 4'b0000 || cwr !== 4'b0000 || mrv !== 1'b0 || mwv !== 1'b0) begin
        failures++;
        $display("FAIL spurious cyc=%0d rready=%b wready=%b mrv=%b mwv=%b required 0000/0000/0/0", i, crr, cwr, mrv, mwv);
      end
    end
    mwr = 1'b0;
    crv[1] = 1'b1;
    cra[15:8] = 8'h33;
    tick;
    checks++;
    if (mrv !== 1'b1 || mra !== 8'h33 || crr !== 4'b0000) begin
      failures++;
      $display("FAIL min_latency_issue mrv=%b addr=%h ready=%b required 1/33/0000", mrv, mra, crr);
    end
    tick;
    checks++;
    if (crr !== 4'b0010 || crd[31:16] !== 16'h1234 || mrv !== 1'b0) begin
      failures++;
      $display("FAIL min_latency_ack ready=%b data=%h mrv=%b required 0010/1234/0", crr, crd[31:16], mrv);
    end
    mrr = 1'b0;
    crv[1] = 1'b0;
    tick;
    checks++;
    if (crr !== 4'b0000) begin
      failures++;
      $display("FAIL min_latency_release ready=%b required 0000", crr);
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_round_robin;
    test_write;
    test_collision;
    test_stall_reset;
    test_spurious_ready;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_controller.md
# mem_controller

Round-robin request controller between the per-thread load/store consumers and the global data/program memory. It accepts read (and optionally write) requests from NUM_CONSUMERS requesters over a valid/ready handshake and forwards one at a time to the single memory port. It returns the memory response to the granted requester. It sits directly upstream of the global memory and is the only master of its port.

## Interface
Parameters:
- ADDR_BITS, 8, address width
- DATA_BITS, 16, data width
- NUM_CONSUMERS, 4, number of requesters (≥2)

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request
- consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  flattened, consumer i at [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  output  NUM_CONSUMERS  read response valid
- consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  flattened read data
- consumer_write_valid  input  NUM_CONSUMERS  per-consumer write request
- consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS
- consumer_write_data  input  NUM_CONSUMERS*DATA_BITS
- consumer_write_ready  output  NUM_CONSUMERS  write acknowledged
- mem_read_valid  output  1
- mem_read_address  output  ADDR_BITS
- mem_read_ready  input  1  memory read data valid
- mem_read_data  input  DATA_BITS
- mem_write_valid  output  1
- mem_write_address  output  ADDR_BITS
- mem_write_data  output  DATA_BITS
- mem_write_ready  input  1  memory write done

## Operation
- All outputs are registered. Reset (reset low) clears every output to 0, state to IDLE, rr_ptr to 0, and granted index to 0. Reset takes effect immediately, including mid-transaction; the in-flight request is dropped.
- States: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE: scan consumers rr_ptr, rr_ptr+1, … (mod NUM_CONSUMERS). The first with read_valid or write_valid is granted. If both are set on the granted consumer, read wins. Latch the address (and data) and assert mem_read_valid or mem_write_valid. Go to READ_WAITING or WRITE_WAITING. With no requests, stay in IDLE.
- READ_WAITING: hold mem_read_valid/address until mem_read_ready=1. Then capture mem_read_data into the granted consumer's data slice, drop mem_read_valid, set consumer_read_ready[g]=1, and go to READ_RELAYING.
- WRITE_WAITING: same flow on mem_write_ready. Set consumer_write_ready[g]=1 and go to WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING: hold ready and data until the granted consumer's matching valid is 0. Then clear ready, set rr_ptr=(g+1) mod NUM_CONSUMERS, and go to IDLE.
- Consumers must hold valid, address and data stable until ready. Dropping valid while WAITING is ignored; the memory transaction completes and relays normally.
- consumer_read_data slices of non-granted consumers retain their last value.
- mem_*_ready is sampled only in the matching WAITING state. Ready asserted in IDLE or RELAYING is ignored.

## Timing
- Request seen at edge N in IDLE → mem_*_valid high after edge N.
- Memory ready sampled at edge M → consumer ready high after edge M. Minimum request-to-response is 2 cycles when memory answers in the first WAITING cycle.
- Consumer valid seen low at edge K → ready low and IDLE after edge K. The next grant is issued no earlier than edge K+1.
- Fairness: a continuously requesting consumer waits at most NUM_CONSUMERS-1 transactions.

## Configuration
- MEM_CONTROLLER_WRITE_EN defined: the write path and WRITE_* states are built as described.
- Undefined: the block is read-only, for use on program memory.
  - consumer_write_* inputs are ignored.
  - consumer_write_ready, mem_write_valid, mem_write_address and mem_write_data are tied to 0.
  - The WRITE_* states do not exist.

## Test plan
- Single read: consumer 2 reads addr 0x15, memory returns 0x00A5 one cycle after mem_read_valid → mem_read_address=0x15, and consumer_read_data slice 2=0x00A5 with consumer_read_ready[2]=1 until consumer drops valid.
- Round-robin: all four consumers read continuously, rr_ptr=0 → grants observed in order 0,1,2,3,0, one mem transaction at a time.
- Write (MEM_CONTROLLER_WRITE_EN): consumer 1 writes 0x0F00 to 0x40 → mem_write_address=0x40, mem_write_data=0x0F00, and consumer_write_ready[1] set after mem_write_ready. Without the macro, mem_write_valid stays 0.
- Read/write collision: consumer 0 asserts read 0x01 and write 0x02 together → read issued first; write issued in the following transaction.
- Stall and reset: memory withholds mem_read_ready for 10 cycles → mem_read_valid and address held stable. Reset pulsed low mid-wait → all outputs 0 immediately and state IDLE.
- Spurious ready: mem_read_ready held high in IDLE with no requests → no consumer ready asserted.
